// File: rtl/pf_vf_rtable_pkg.sv
// rtl/pf_vf_rtable_pkg.sv - shared types and widths for the PF/VF routing-table lookup engine
package pf_vf_rtable_pkg;

  localparam int RT_PF_W    = 3;
  localparam int RT_VF_W    = 11;
  localparam int RT_PORT_W  = 2;
  localparam int MISS_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [RT_PF_W-1:0]   pf;
    logic [RT_VF_W-1:0]   vf;
    logic                 vf_active;
    logic                 vf_wild;
    logic [RT_PORT_W-1:0] port;
  } t_rtable_entry;

  // Index/port field width; a single-value field still needs one bit.
  function automatic int rt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pf_vf_rtable_prio_enc.sv
// rtl/pf_vf_rtable_prio_enc.sv - lowest-index-wins priority encoder with hit flag
module pf_vf_rtable_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic             hit_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    hit_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/pf_vf_rtable_lut.sv
// rtl/pf_vf_rtable_lut.sv - runtime-programmable PF/VF routing table, 2-stage lookup; PFVF_RTABLE_MISS_CNT_EN builds the miss counter
module pf_vf_rtable_lut
  import pf_vf_rtable_pkg::*;
#(
  parameter int NUM_ENTRIES  = 8,
  parameter int NUM_PORT     = 4,
  parameter int PF_WIDTH     = RT_PF_W,
  parameter int VF_WIDTH     = RT_VF_W,
  parameter int DEFAULT_PORT = 0,
  parameter int PORT_WIDTH   = rt_width(NUM_PORT),
  parameter int IDX_WIDTH    = rt_width(NUM_ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic                  wr_valid,
  input  logic [PF_WIDTH-1:0]   wr_pf,
  input  logic [VF_WIDTH-1:0]   wr_vf,
  input  logic                  wr_vf_active,
  input  logic                  wr_vf_wild,
  input  logic [PORT_WIDTH-1:0] wr_port,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [PF_WIDTH-1:0]   req_pf,
  input  logic [VF_WIDTH-1:0]   req_vf,
  input  logic                  req_vf_active,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [PORT_WIDTH-1:0] rsp_port,
  output logic                  rsp_hit,
  output logic [IDX_WIDTH-1:0]  rsp_idx,
  output logic [15:0]           miss_cnt,
  input  logic                  miss_cnt_clr
);

  t_rtable_entry tbl_q [NUM_ENTRIES];
  t_rtable_entry wr_entry;

  logic [NUM_ENTRIES-1:0]                 match;
  logic [NUM_ENTRIES-1:0][PORT_WIDTH-1:0] port_vec;
  logic                                   en;

  logic                                   s1_valid_q;
  logic [NUM_ENTRIES-1:0]                 match_q;
  logic [NUM_ENTRIES-1:0][PORT_WIDTH-1:0] s1_port_q;

  logic                  enc_hit;
  logic [IDX_WIDTH-1:0]  enc_idx;
  logic                  rsp_valid_q;
  logic                  rsp_hit_q;
  logic [PORT_WIDTH-1:0] rsp_port_q;
  logic [IDX_WIDTH-1:0]  rsp_idx_q;

  always_comb begin
    wr_entry           = '0;
    wr_entry.valid     = wr_valid;
    wr_entry.pf        = RT_PF_W'(wr_pf);
    wr_entry.vf        = RT_VF_W'(wr_vf);
    wr_entry.vf_active = wr_vf_active;
    wr_entry.vf_wild   = wr_vf_wild & wr_vf_active;
    wr_entry.port      = RT_PORT_W'(wr_port);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) tbl_q[i] <= '0;
    end else if (wr_en && (int'(wr_idx) < NUM_ENTRIES)) begin
      tbl_q[wr_idx] <= wr_entry;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match[i] = tbl_q[i].valid
              && (tbl_q[i].pf == RT_PF_W'(req_pf))
              && (tbl_q[i].vf_active == req_vf_active)
              && (tbl_q[i].vf_wild || !tbl_q[i].vf_active || (tbl_q[i].vf == RT_VF_W'(req_vf)));
      port_vec[i] = PORT_WIDTH'(tbl_q[i].port);
    end
  end

  assign en        = !rsp_valid_q || rsp_ready;
  assign req_ready = en;

  // Ports are captured with the match vector so a later write cannot alter an in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      match_q    <= '0;
      s1_port_q  <= '0;
    end else if (en) begin
      s1_valid_q <= req_valid;
      if (req_valid) begin
        match_q   <= match;
        s1_port_q <= port_vec;
      end
    end
  end

  pf_vf_rtable_prio_enc #(
    .N     (NUM_ENTRIES),
    .IDX_W (IDX_WIDTH)
  ) u_prio_enc (
    .req_i (match_q),
    .hit_o (enc_hit),
    .idx_o (enc_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_port_q  <= '0;
      rsp_idx_q   <= '0;
    end else if (en) begin
      rsp_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rsp_hit_q  <= enc_hit;
        rsp_idx_q  <= enc_idx;
        rsp_port_q <= enc_hit ? s1_port_q[enc_idx] : PORT_WIDTH'(DEFAULT_PORT);
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_port  = rsp_port_q;
  assign rsp_idx   = rsp_idx_q;

`ifdef PFVF_RTABLE_MISS_CNT_EN
  logic [MISS_CNT_W-1:0] miss_cnt_q;
  logic [MISS_CNT_W-1:0] miss_cnt_d;
  logic                  miss_xfer;

  assign miss_xfer = rsp_valid_q && rsp_ready && !rsp_hit_q;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_cnt_clr) begin
      miss_cnt_d = '0;
    end else if (miss_xfer && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cnt_q <= '0;
    end else if (miss_cnt_clr || miss_xfer) begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_cnt = 16'(miss_cnt_q);
`else
  logic unused_miss_cnt_clr;
  assign unused_miss_cnt_clr = miss_cnt_clr;
  assign miss_cnt            = '0;
`endif

endmodule

// File: tb/tb_pf_vf_rtable_lut.sv
// tb/tb_pf_vf_rtable_lut.sv - scoreboard bench for pf_vf_rtable_lut
module tb_pf_vf_rtable_lut;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_idx;
  logic        wr_valid;
  logic [2:0]  wr_pf;
  logic [10:0] wr_vf;
  logic        wr_vf_active;
  logic        wr_vf_wild;
  logic [1:0]  wr_port;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_pf;
  logic [10:0] req_vf;
  logic        req_vf_active;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_port;
  logic        rsp_hit;
  logic [2:0]  rsp_idx;
  logic [15:0] miss_cnt;
  logic        miss_cnt_clr;

  pf_vf_rtable_lut dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_valid      (wr_valid),
    .wr_pf         (wr_pf),
    .wr_vf         (wr_vf),
    .wr_vf_active  (wr_vf_active),
    .wr_vf_wild    (wr_vf_wild),
    .wr_port       (wr_port),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pf        (req_pf),
    .req_vf        (req_vf),
    .req_vf_active (req_vf_active),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_port      (rsp_port),
    .rsp_hit       (rsp_hit),
    .rsp_idx       (rsp_idx),
    .miss_cnt      (miss_cnt),
    .miss_cnt_clr  (miss_cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] port;
    logic       hit;
    logic [2:0] idx;
    int         acc;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  bit          lat_chk = 1'b0;
  logic [15:0] exp_miss = 16'h0;
  bit          exp_miss_load = 1'b0;
  bit          miss_xfer_exp = 1'b0;
  bit          prev_stall = 1'b0;
  logic [1:0]  prev_port;
  logic        prev_hit;
  logic [2:0]  prev_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_miss <= 16'h0;
    end else begin
`ifdef PFVF_RTABLE_MISS_CNT_EN
      if (exp_miss_load) exp_miss <= 16'hFFFE;
      else if (miss_cnt_clr) exp_miss <= 16'h0;
      else if (miss_xfer_exp && exp_miss != 16'hFFFF) exp_miss <= exp_miss + 16'h1;
`endif
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL unexpected_rsp: got port %0d with no request outstanding", rsp_port);
          miss_xfer_exp = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("rsp_port", 32'(rsp_port), 32'(e.port));
          chk("rsp_hit", 32'(rsp_hit), 32'(e.hit));
          chk("rsp_idx", 32'(rsp_idx), 32'(e.idx));
          chk("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
          if (lat_chk) chk("latency", 32'(cyc - e.acc), 32'd2);
          miss_xfer_exp = !e.hit;
        end
      end else begin
        miss_xfer_exp = 1'b0;
      end
      if (rsp_valid && !rsp_ready) begin
        if (prev_stall) begin
          chk("stall_port", 32'(rsp_port), 32'(prev_port));
          chk("stall_hit", 32'(rsp_hit), 32'(prev_hit));
          chk("stall_idx", 32'(rsp_idx), 32'(prev_idx));
        end
        prev_stall = 1'b1;
        prev_port  = rsp_port;
        prev_hit   = rsp_hit;
        prev_idx   = rsp_idx;
      end else begin
        prev_stall = 1'b0;
      end
    end else begin
      miss_xfer_exp = 1'b0;
      prev_stall    = 1'b0;
    end
  end

  task automatic issue(input logic [2:0] pf, input logic [10:0] vf, input logic va,
                       input logic [1:0] port, input logic hit, input logic [2:0] idx);
    int n = 0;
    req_valid = 1'b1;
    req_pf = pf;
    req_vf = vf;
    req_vf_active = va;
    #1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      total++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 50 cycles");
    end else begin
      sb.push_back('{port, hit, idx, cyc});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [2:0] pf, input logic [10:0] vf,
                    input logic va, input logic wild, input logic [1:0] port);
    wr_en = 1'b1;
    wr_idx = idx;
    wr_valid = 1'b1;
    wr_pf = pf;
    wr_vf = vf;
    wr_vf_active = va;
    wr_vf_wild = wild;
    wr_port = port;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  // Stream: pf, vf, vf_active, exp port, exp hit, exp idx
  logic [2:0]  st_pf   [8] = '{3'd2, 3'd0, 3'd0, 3'd3, 3'd2,   3'd1, 3'd0, 3'd2};
  logic [10:0] st_vf   [8] = '{11'd0, 11'd5, 11'd9, 11'd0, 11'd77, 11'd5, 11'd0, 11'd5};
  logic        st_va   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,   1'b1, 1'b1, 1'b1};
  logic [1:0]  st_port [8] = '{2'd3, 2'd2, 2'd3, 2'd0, 2'd3,   2'd0, 2'd3, 2'd0};
  logic        st_hit  [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,   1'b0, 1'b1, 1'b0};
  logic [2:0]  st_idx  [8] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0,   3'd0, 3'd2, 3'd0};

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0; wr_pf = '0; wr_vf = '0;
    wr_vf_active = 1'b0; wr_vf_wild = 1'b0; wr_port = '0;
    req_valid = 1'b0; req_pf = '0; req_vf = '0; req_vf_active = 1'b0;
    rsp_ready = 1'b1; miss_cnt_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_port", 32'(rsp_port), 32'd0);
    chk("rst_rsp_hit", 32'(rsp_hit), 32'd0);
    chk("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);

    lat_chk = 1'b1;
    issue(3'd1, 11'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    drain();

    wr(3'd2, 3'd0, 11'd0, 1'b1, 1'b1, 2'd3);
    wr(3'd1, 3'd0, 11'd5, 1'b1, 1'b0, 2'd2);
    issue(3'd0, 11'd5, 1'b1, 2'd2, 1'b1, 3'd1);
    issue(3'd0, 11'd7, 1'b1, 2'd3, 1'b1, 3'd2);
    issue(3'd0, 11'd5, 1'b0, 2'd0, 1'b0, 3'd0);
    drain();

    wr(3'd0, 3'd2, 11'd0, 1'b0, 1'b0, 2'd3);
    for (int i = 0; i < 8; i++) issue(st_pf[i], st_vf[i], st_va[i], st_port[i], st_hit[i], st_idx[i]);
    drain();

    lat_chk = 1'b0;
    rsp_ready = 1'b0;
    fork
      begin
        issue(3'd2, 11'd0, 1'b0, 2'd3, 1'b1, 3'd0);
        issue(3'd0, 11'd1, 1'b1, 2'd3, 1'b1, 3'd2);
        issue(3'd0, 11'd5, 1'b1, 2'd2, 1'b1, 3'd1);
        issue(3'd6, 11'd0, 1'b0, 2'd0, 1'b0, 3'd0);
      end
      begin
        repeat (3) @(negedge clk);
        #1;
        chk("stall_req_ready", 32'(req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rsp_ready = 1'b1;
      end
    join
    drain();
    lat_chk = 1'b1;

    wr_en = 1'b1; wr_idx = 3'd0; wr_valid = 1'b1; wr_pf = 3'd2; wr_vf = '0;
    wr_vf_active = 1'b0; wr_vf_wild = 1'b0; wr_port = 2'd1;
    issue(3'd2, 11'd0, 1'b0, 2'd3, 1'b1, 3'd0);
    wr_en = 1'b0;
    issue(3'd2, 11'd0, 1'b0, 2'd1, 1'b1, 3'd0);
    drain();

    issue(3'd2, 11'd0, 1'b0, 2'd1, 1'b1, 3'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    issue(3'd2, 11'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    drain();

`ifdef PFVF_RTABLE_MISS_CNT_EN
    force dut.miss_cnt_q = 16'hFFFE;
    exp_miss_load = 1'b1;
    @(negedge clk);
    release dut.miss_cnt_q;
    exp_miss_load = 1'b0;
    #1;
    chk("miss_cnt_loaded", 32'(miss_cnt), 32'hFFFE);
    @(negedge clk);
`endif
    for (int i = 0; i < 3; i++) issue(3'd5, 11'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    drain();
    issue(3'd5, 11'd0, 1'b0, 2'd0, 1'b0, 3'd0);
    @(negedge clk);
    miss_cnt_clr = 1'b1;
    @(negedge clk);
    miss_cnt_clr = 1'b0;
    drain();
    #1;
    chk("final_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    chk("final_miss_cleared", 32'(exp_miss), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
